ped_signal_controller: RTL and testbench

//  Downstream of traffic_light_controller. Consumes its red/yellow/green lamp outputs plus a

---
 rtl/ped_signal_controller_pkg.sv | 25 ++
 rtl/ped_signal_controller_button_sync.sv | 23 ++
 rtl/ped_signal_controller.sv | 184 ++++++++++++++++++
 tb/tb_ped_signal_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_signal_controller_pkg.sv
// Shared types and defaults for the pedestrian crossing controller.
// Holds the FSM state enum, default timings and the lamp-set check.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2,
    FAULT = 2'd3
  } ped_state_t;

  localparam int unsigned WALK_CYCLES_DEF  = 5;
  localparam int unsigned FLASH_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF        = 4;

  // Exactly one lamp lit: odd population and not all three.
  function automatic logic lamp_set_ok(
    input logic r,
    input logic y,
    input logic g
  );
    return (r ^ y ^ g) & ~(r & y & g);
  endfunction

endpackage

// File: rtl/ped_signal_controller_button_sync.sv
// Push-button front end: 2-flop synchroniser plus rising-edge pulse.
// Ports: clk, reset (sync, active-high), btn_i (async), rise_o (1-cycle pulse).
module ped_button_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect.
  logic [2:0] sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], btn_i};
    end
  end

  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/ped_signal_controller.sv
// Crosswalk WALK / DONT_WALK controller slaved to the vehicle lamps.
// Ports: clk, reset (sync high), red/yellow/green_light, ped_button in;
//   walk, dont_walk, countdown[CNT_W], request_pending, fault out.
// Macro LAMP_CHECK_EN enables the sticky lamp-set FAULT state.
module ped_signal_controller
  import tlc_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = WALK_CYCLES_DEF,
  parameter int unsigned FLASH_CYCLES = FLASH_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red_light,
  input  logic             yellow_light,
  input  logic             green_light,
  input  logic             ped_button,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             request_pending,
  output logic             fault
);

  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ped_state_t       state_q;
  ped_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             red_q;
  logic             req_q;
  logic             req_d;
  logic             press;
  logic             red_rise;
  logic             grant;
  logic             lamp_bad;

  logic             walk_q;
  logic             walk_d;
  logic             dw_q;
  logic             dw_d;
  logic [CNT_W-1:0] cd_q;
  logic [CNT_W-1:0] cd_d;

  ped_button_sync u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (ped_button),
    .rise_o (press)
  );

  assign red_rise = red_light & ~red_q;

`ifdef LAMP_CHECK_EN
  logic ill_q;
  logic illegal;
  logic fault_q;

  assign illegal  = ~lamp_set_ok(red_light, yellow_light, green_light);
  // Two consecutive illegal samples filter single-cycle lamp glitches.
  assign lamp_bad = illegal & ill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ill_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      ill_q   <= illegal;
      fault_q <= (state_d == FAULT);
    end
  end

  assign fault = fault_q;
`else
  logic unused_lamps;
  assign unused_lamps = yellow_light ^ green_light;
  assign lamp_bad     = 1'b0;
  assign fault        = 1'b0;
`endif

  // State register and input history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // A red phase already running at release must not look like a rise.
      red_q   <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      red_q   <= red_light;
      req_q   <= req_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    if (lamp_bad || (state_q == FAULT)) begin
      state_d = FAULT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (red_rise && (req_q || press)) begin
            state_d = WALK;
            cnt_d   = WALK_LD;
            grant   = 1'b1;
          end
        end
        WALK: begin
          if (!red_light) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = FLASH;
            cnt_d   = FLASH_LD;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        FLASH: begin
          if (!red_light || (cnt_q == '0)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // A grant consumes both the latched request and a same-cycle press.
  assign req_d = grant ? 1'b0 : (req_q | press);

  // Output logic, looking at the next state so lamps change on the
  // same edge as the state.
  always_comb begin
    walk_d = 1'b0;
    dw_d   = 1'b1;
    cd_d   = '0;
    unique case (state_d)
      WALK: begin
        walk_d = 1'b1;
        dw_d   = 1'b0;
      end
      FLASH: begin
        dw_d = (state_q == FLASH) ? ~dw_q : 1'b1;
        cd_d = cnt_d + ONE;
      end
      default: begin
        dw_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      walk_q <= 1'b0;
      dw_q   <= 1'b1;
      cd_q   <= '0;
    end else begin
      walk_q <= walk_d;
      dw_q   <= dw_d;
      cd_q   <= cd_d;
    end
  end

  assign walk            = walk_q;
  assign dont_walk       = dw_q;
  assign countdown       = cd_q;
  assign request_pending = req_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Self-checking bench for ped_signal_controller.
// Timeline model of the crossing plus directed literal checks.
module tb_ped_signal_controller;

  localparam int W  = 5;
  localparam int F  = 4;
  localparam int CW = 4;

`ifdef LAMP_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  localparam logic [11:0] EXP_RW6 = LC ? 12'h000 : 12'h01F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic red_light = 1'b0;
  logic yellow_light = 1'b0;
  logic green_light = 1'b0;
  logic ped_button = 1'b0;
  logic walk;
  logic dont_walk;
  logic [CW-1:0] countdown;
  logic request_pending;
  logic fault;

  int checks = 0;
  int errors = 0;

  ped_signal_controller #(
    .WALK_CYCLES  (W),
    .FLASH_CYCLES (F),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .red_light       (red_light),
    .yellow_light    (yellow_light),
    .green_light     (green_light),
    .ped_button      (ped_button),
    .walk            (walk),
    .dont_walk       (dont_walk),
    .countdown       (countdown),
    .request_pending (request_pending),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // Model: k = edges since WALK was granted (-1 when no crossing active).
  int k = -1;
  bit m_req = 0;
  bit m_flt = 0;
  bit m_illp = 0;
  bit m_redp = 1;
  bit h1 = 0;
  bit h2 = 0;
  bit h3 = 0;
  bit chk_en = 0;

  always @(posedge clk) begin : model
    bit pe;
    bit rise;
    bit ill;
    int nl;
    pe   = h2 & ~h3;
    nl   = int'(red_light) + int'(yellow_light) + int'(green_light);
    ill  = LC && (nl != 1);
    rise = red_light && !m_redp;
    if (reset) begin
      k = -1; m_req = 0; m_flt = 0; m_illp = 0; m_redp = 1;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      if (m_flt || (ill && m_illp)) begin
        m_flt = 1; k = -1; m_req = m_req | pe;
      end else if (k >= 0) begin
        if (!red_light) k = -1;
        else begin
          k++;
          if (k >= W + F) k = -1;
        end
        m_req = m_req | pe;
      end else if (rise && (m_req || pe)) begin
        k = 0; m_req = 0;
      end else begin
        m_req = m_req | pe;
      end
      m_illp = ill; m_redp = red_light;
      h3 = h2; h2 = h1; h1 = ped_button;
    end
  end

  always @(negedge clk) begin : compare
    bit ew;
    bit edw;
    int ecd;
    if (chk_en) begin
      ew = 0; edw = 1; ecd = 0;
      if (!m_flt && k >= 0) begin
        if (k < W) begin
          ew = 1; edw = 0;
        end else begin
          edw = ((k - W) % 2) == 0;
          ecd = F - (k - W);
        end
      end
      chk("walk", 32'(walk), 32'(ew));
      chk("dont_walk", 32'(dont_walk), 32'(edw));
      chk("countdown", 32'(countdown), 32'(ecd));
      chk("request_pending", 32'(request_pending), 32'(m_req));
      chk("fault", 32'(fault), 32'(m_flt));
    end
  end

  task automatic cyc(input bit r, input bit y, input bit g, input bit b);
    red_light = r; yellow_light = y; green_light = g; ped_button = b;
    @(negedge clk);
  endtask

  logic [31:0] rw;
  logic [31:0] rdw;
  int rcd[32];
  bit pend_pre;
  int wstarts;

  task automatic run_seq(input int ng, input int ny, input int nr,
                         input logic [31:0] pg, input logic [31:0] py,
                         input logic [31:0] pr);
    bit prev_w;
    for (int i = 0; i < ng; i++) cyc(0, 0, 1, pg[i]);
    for (int i = 0; i < ny; i++) cyc(0, 1, 0, py[i]);
    pend_pre = request_pending;
    rw = '0; rdw = '0; wstarts = 0; prev_w = walk;
    for (int i = 0; i < nr; i++) begin
      cyc(1, 0, 0, pr[i]);
      rw[i] = walk; rdw[i] = dont_walk; rcd[i] = int'(countdown);
      if (walk && !prev_w) wstarts++;
      prev_w = walk;
    end
  endtask

  initial begin : stim
    int acc;
    cyc(0, 0, 1, 0);
    chk_en = 1;
    chk("rst_walk", 32'(walk), 0);
    chk("rst_dont_walk", 32'(dont_walk), 1);
    chk("rst_countdown", 32'(countdown), 0);
    chk("rst_pending", 32'(request_pending), 0);
    chk("rst_fault", 32'(fault), 0);
    reset = 0;
    cyc(0, 0, 1, 0);

    // 1: press on green cycle 3, served at red rise
    run_seq(8, 2, 12, 32'h8, 0, 0);
    chk("t1_pend_pre", 32'(pend_pre), 1);
    chk("t1_walk_seq", 32'(rw[11:0]), 32'h01F);
    chk("t1_dw_seq", 32'(rdw[11:0]), 32'hEA0);
    chk("t1_cd_seq", 32'((rcd[5] << 12) | (rcd[6] << 8) | (rcd[7] << 4) | rcd[8]),
        32'h4321);
    chk("t1_cd_walk", 32'(rcd[0]), 0);

    // 2: full sequence without a press
    run_seq(8, 2, 12, 0, 0, 0);
    chk("t2_walk", 32'(rw[11:0]), 0);
    chk("t2_dw", 32'(rdw[11:0]), 32'hFFF);
    acc = 0;
    for (int i = 0; i < 12; i++) acc += rcd[i];
    chk("t2_cd", 32'(acc), 0);

    // 3a: press edge lands on the red-rise edge
    run_seq(8, 2, 12, 0, 32'h3, 0);
    chk("t3_pend_pre", 32'(pend_pre), 0);
    chk("t3_walk_first", 32'(rw[0]), 1);
    // 3b: three presses -> one crossing
    run_seq(8, 2, 12, 32'h92, 0, 0);
    chk("t3_starts", 32'(wstarts), 1);
    chk("t3_walk_cycles", 32'($countones(rw)), 5);

    // 4: abort in WALK cycle 3, then a press in FLASH
    run_seq(8, 2, 3, 32'h4, 0, 0);
    chk("t4_walk3", 32'(rw[2:0]), 7);
    cyc(0, 0, 1, 0);
    chk("t4_ab_walk", 32'(walk), 0);
    chk("t4_ab_dw", 32'(dont_walk), 1);
    chk("t4_ab_cd", 32'(countdown), 0);
    chk("t4_ab_pend", 32'(request_pending), 0);
    run_seq(7, 2, 12, 32'h2, 0, 32'h40);
    chk("t4_flash_pend", 32'(request_pending), 1);
    run_seq(8, 2, 12, 0, 0, 0);
    chk("t4_pend_pre", 32'(pend_pre), 1);
    chk("t4_walk_next", 32'(rw[0]), 1);

    // 5: reset two cycles mid-WALK, released during red
    run_seq(8, 2, 2, 32'h4, 0, 0);
    reset = 1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t5_walk", 32'(walk), 0);
    chk("t5_dw", 32'(dont_walk), 1);
    chk("t5_pend", 32'(request_pending), 0);
    reset = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, i == 2);
      acc += int'(walk);
    end
    chk("t5_no_walk", 32'(acc), 0);
    run_seq(8, 2, 12, 0, 0, 0);
    chk("t5_walk_next", 32'(rw[0]), 1);

    // 6: lamp check
    run_seq(8, 2, 1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("t6_one_cycle", 32'(fault), 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("t6_fault", 32'(fault), 32'(LC));
    chk("t6_dw", 32'(dont_walk), 1);
    run_seq(8, 2, 12, 32'h8, 0, 0);
    chk("t6_sticky", 32'(fault), 32'(LC));
    chk("t6_walk", 32'(rw[11:0]), 32'(EXP_RW6));
    reset = 1;
    cyc(0, 0, 1, 0);
    reset = 0;
    cyc(0, 0, 1, 0);
    chk("t6_cleared", 32'(fault), 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
